adc_trigger_capture: RTL
========================

// Module: adc_trigger_capture
// PURPOSE
//  Downstream consumer of the 8-bit ADC sample stream (AD bus, sampled on CLK32MHz).
//  - Stores a window of DEPTH samples around a level-crossing trigger in block RAM.
//  - Keeps PRETRIG samples before the trigger.
//  - Streams the window out oldest-first over a valid/ready port (to a UART or DAC stage).
// PARAMETERS
//  DEPTH       256    capture window in samples; power of 2, 16..4096
//  PRETRIG     64     samples kept before trigger sample; 0 <= PRETRIG < DEPTH
//  AUTO_CYCLES 65536  auto-trigger timeout in clocks (only with ADC_CAPTURE_AUTOTRIG_EN)
// PORTS
//  CLK32MHz    in   1  sample/system clock; ADC and DAC run on it
//  greset      in   1  synchronous, active-high reset
//  ad_data     in   8  ADC sample, unsigned offset-binary, new value every clock
//  arm         in   1  one-clock pulse: start a capture; ignored unless state IDLE
//  trig_level  in   8  trigger threshold, unsigned
//  trig_rising in   1  1: rising crossing, 0: falling crossing
//  busy        out  1  high in every state except IDLE
//  triggered   out  1  one-clock pulse on the clock the trigger sample is written
//  rd_valid    out  1  readout data valid
//  rd_ready    in   1  readout sink accepts data
//  rd_data     out  8  readout sample
//  rd_last     out  1  high with the final (DEPTH-th) readout sample
// BEHAVIOUR
//  - Reset: state IDLE, wr_ptr=0, counters=0; busy, triggered, rd_valid, rd_last = 0; rd_data=0.
//  - Reset mid-operation aborts immediately; RAM contents are don't-care.
//  - States and transitions:
//    IDLE -arm-> PRE; PRE -PRETRIG samples written-> ARMED;
//    ARMED -trigger-> POST; POST -(DEPTH-PRETRIG) samples written, incl. trigger-> READ;
//    READ -last beat accepted-> IDLE.
//  - PRETRIG=0: PRE lasts 0 clocks (IDLE->ARMED directly).
//  - Write side: in PRE/ARMED/POST every clock writes ad_data at wr_ptr; wr_ptr += 1 mod DEPTH (wraps).
//  - Trigger compare uses prev (previous clock's sample) and cur:
//    rising: prev < trig_level && cur >= trig_level;
//    falling: prev > trig_level && cur <= trig_level.
//  - prev is valid only after the first sample written since arm: no trigger on the first sample.
//  - Crossings during PRE are ignored.
//  - trig_addr latches wr_ptr of the trigger sample.
//  - Readout start address = (trig_addr - PRETRIG) mod DEPTH; reads DEPTH samples, address wraps.
//  - RAM read has 1-clock latency; output register holds rd_data.
//  - First rd_valid comes 2 clocks after entering READ.
//  - Handshake: beat transfers when rd_valid && rd_ready.
//  - rd_data and rd_last stay stable while rd_valid && !rd_ready.
//  - rd_valid never drops without a transfer.
//  - Back-to-back beats are sustained at 1/clock when rd_ready is held high.
//  - After the last transfer: rd_valid=0 next clock, state IDLE.
//  - arm in any non-IDLE state: ignored, no side effects.
//  - arm on the same clock as the final transfer: ignored.
//  - triggered is never asserted outside ARMED->POST.
// CONFIGURATION
//  ADC_CAPTURE_AUTOTRIG_EN defined:
//    - In ARMED, a counter of clocks since entering ARMED runs.
//    - At AUTO_CYCLES with no crossing, a trigger is forced on that clock's sample.
//    - Forced trigger pulses triggered; behaviour is otherwise identical.
//  Not defined: no counter logic; ARMED waits indefinitely for a crossing.
// STRUCTURE
//  - Package adc_capture_pkg:
//    - sample_t = logic [7:0]
//    - cap_state_t enum {IDLE, PRE, ARMED, POST, READ}
//    - function addr_w(DEPTH) = $clog2(DEPTH)
//  - Sub-module capture_ram:
//    - simple dual-port, 1 write / 1 registered read port, DEPTH x 8, same clock
//    - infers SB_RAM40_4K
//  - Top of block: FSM, pointers/counters, trigger comparator, output register.
// TESTING
//  1. Ramp ad_data = 0,1,2..., level=100, rising, arm; PRETRIG=64, DEPTH=256:
//     -> triggered on sample 100; readout 36..291 (mod 256 values), rd_last on 256th beat.
//  2. Sine input, falling, level=128:
//     -> beat 64 (0-based) is the first sample <=128 after one >128; beat 63 > 128.
//  3. Random rd_ready (50%):
//     -> no lost/duplicated beats, rd_data stable while stalled, exactly 256 beats.
//  4. Constant ad_data=50, level=100:
//     -> no trigger, busy stays 1; with ADC_CAPTURE_AUTOTRIG_EN, AUTO_CYCLES=1000:
//     -> forced trigger 1000 clocks after ARMED, readout all 50.
//  5. Crossing inside PRE, arm pulsed during POST/READ
//     -> both ignored; capture proceeds unchanged.
//  6. greset asserted mid-POST and mid-READ
//     -> next clock IDLE, rd_valid=0, busy=0; a fresh arm captures correctly.

Source files
------------

// File: rtl/adc_capture_pkg.sv
// Shared types for the ADC trigger/capture block: sample type, capture states,
// and the address-width helper used to size the window RAM.
package adc_capture_pkg;

    typedef logic [7:0] sample_t;

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        ARMED,
        POST,
        READ
    } cap_state_t;

    function automatic int addr_w(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/adc_trigger_capture_if.sv
// Valid/ready readout port of the capture block; master drives samples, slave accepts them.
interface adc_trigger_capture_if;
    import adc_capture_pkg::*;

    logic    rd_valid;
    logic    rd_ready;
    sample_t rd_data;
    logic    rd_last;

    modport master (output rd_valid, output rd_data, output rd_last, input rd_ready);
    modport slave  (input rd_valid, input rd_data, input rd_last, output rd_ready);

endinterface

// File: rtl/capture_ram.sv
// Simple dual-port capture RAM, DEPTH x 8: one write port, one registered read port
// with read enable (output holds when not reading), single clock.
module capture_ram
    import adc_capture_pkg::*;
#(
    parameter int DEPTH = 256
) (
    input  logic                     CLK32MHz,
    input  logic                     i_we,
    input  logic [addr_w(DEPTH)-1:0] i_waddr,
    input  sample_t                  i_wdata,
    input  logic                     i_re,
    input  logic [addr_w(DEPTH)-1:0] i_raddr,
    output sample_t                  o_rdata
);

    sample_t r_mem [DEPTH];
    sample_t r_rdata;

    always_ff @(posedge CLK32MHz) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    always_ff @(posedge CLK32MHz) begin
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/adc_trigger_capture.sv
// Captures a DEPTH-sample window around a level crossing (PRETRIG samples of history) and
// streams it out oldest-first. ADC_CAPTURE_AUTOTRIG_EN adds a forced trigger after AUTO_CYCLES.
module adc_trigger_capture
    import adc_capture_pkg::*;
#(
    parameter int DEPTH       = 256,
    parameter int PRETRIG     = 64,
    parameter int AUTO_CYCLES = 65536
) (
    input  logic                  CLK32MHz,
    input  logic                  greset,
    input  sample_t               ad_data,
    input  logic                  arm,
    input  sample_t               trig_level,
    input  logic                  trig_rising,
    output logic                  busy,
    output logic                  triggered,
    adc_trigger_capture_if.master rd
);

    // state | meaning
    // IDLE  | waiting for arm
    // PRE   | filling the pre-trigger history, crossings ignored
    // ARMED | writing every clock, watching for a crossing
    // POST  | writing the rest of the window after the trigger sample
    // READ  | streaming the window out oldest-first

    localparam int AW = addr_w(DEPTH);
    localparam logic [AW-1:0] PRE_LOAD  = AW'(PRETRIG - 1);
    localparam logic [AW-1:0] POST_LOAD = AW'(DEPTH - PRETRIG - 2);
    localparam logic [AW-1:0] LAST_BEAT = AW'(DEPTH - 1);
    localparam logic [AW-1:0] PRE_OFS   = AW'(PRETRIG);

    if (DEPTH < 16 || DEPTH > 4096 || (DEPTH & (DEPTH - 1)) != 0 ||
        PRETRIG < 0 || PRETRIG >= DEPTH || AUTO_CYCLES < 1) begin : g_bad_params
        $error("adc_trigger_capture: illegal DEPTH/PRETRIG/AUTO_CYCLES");
    end

    cap_state_t    r_state;
    cap_state_t    w_state_nx;
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_cnt;
    sample_t       r_prev;
    logic          r_prev_vld;
    logic [AW-1:0] r_rd_addr;
    logic [AW-1:0] r_rd_cnt;
    logic          r_rd_issuing;
    logic          r_s1_vld;
    logic          r_s1_last;
    logic          r_rd_valid;
    sample_t       r_rd_data;
    logic          r_rd_last;

    logic    w_we;
    logic    w_cross;
    logic    w_auto_fire;
    logic    w_trig;
    logic    w_cnt_tc;
    logic    w_out_take;
    logic    w_re;
    logic    w_final;
    sample_t w_ram_rdata;

    assign w_we     = (r_state == PRE) || (r_state == ARMED) || (r_state == POST);
    assign w_cross  = r_prev_vld &&
                      (trig_rising ? (r_prev < trig_level && ad_data >= trig_level)
                                   : (r_prev > trig_level && ad_data <= trig_level));
    assign w_trig   = (r_state == ARMED) && (w_cross || w_auto_fire);
    assign w_cnt_tc = (r_cnt == '0);

    // Two-stage read pipe (RAM output, then output register); a fetch is issued only
    // when the RAM stage is empty or draining, so stalls never lose a beat.
    assign w_out_take = !r_rd_valid || rd.rd_ready;
    assign w_re       = (r_state == READ) && r_rd_issuing && (!r_s1_vld || w_out_take);
    assign w_final    = r_rd_valid && rd.rd_ready && r_rd_last;

    always_ff @(posedge CLK32MHz) begin
        if (greset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            IDLE:    if (arm) w_state_nx = (PRETRIG == 0) ? ARMED : PRE;
            PRE:     if (w_cnt_tc) w_state_nx = ARMED;
            ARMED:   if (w_trig) w_state_nx = (DEPTH - PRETRIG == 1) ? READ : POST;
            POST:    if (w_cnt_tc) w_state_nx = READ;
            READ:    if (w_final) w_state_nx = IDLE;
            default: w_state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy      = (r_state != IDLE);
        triggered = w_trig;
    end

    always_ff @(posedge CLK32MHz) begin
        if (greset) begin
            r_wr_ptr     <= '0;
            r_cnt        <= '0;
            r_prev       <= '0;
            r_prev_vld   <= 1'b0;
            r_rd_addr    <= '0;
            r_rd_cnt     <= '0;
            r_rd_issuing <= 1'b0;
            r_s1_vld     <= 1'b0;
            r_s1_last    <= 1'b0;
            r_rd_valid   <= 1'b0;
            r_rd_data    <= '0;
            r_rd_last    <= 1'b0;
        end else begin
            if (w_we) begin
                r_wr_ptr   <= r_wr_ptr + AW'(1);
                r_prev     <= ad_data;
                r_prev_vld <= 1'b1;
            end

            case (r_state)
                IDLE: begin
                    if (arm) begin
                        r_prev_vld <= 1'b0;
                        r_cnt      <= PRE_LOAD;
                    end
                end
                PRE, POST: r_cnt <= r_cnt - AW'(1);
                ARMED: begin
                    if (w_trig) begin
                        r_cnt        <= POST_LOAD;
                        r_rd_addr    <= r_wr_ptr - PRE_OFS;
                        r_rd_cnt     <= LAST_BEAT;
                        r_rd_issuing <= 1'b1;
                    end
                end
                default: ;
            endcase

            if (w_re) begin
                r_rd_addr <= r_rd_addr + AW'(1);
                r_rd_cnt  <= r_rd_cnt - AW'(1);
                r_s1_vld  <= 1'b1;
                r_s1_last <= (r_rd_cnt == '0);
                if (r_rd_cnt == '0) begin
                    r_rd_issuing <= 1'b0;
                end
            end else if (w_out_take) begin
                r_s1_vld <= 1'b0;
            end

            if (w_out_take) begin
                r_rd_valid <= r_s1_vld;
                if (r_s1_vld) begin
                    r_rd_data <= w_ram_rdata;
                    r_rd_last <= r_s1_last;
                end else begin
                    r_rd_last <= 1'b0;
                end
            end
        end
    end

`ifdef ADC_CAPTURE_AUTOTRIG_EN
    localparam int TW = $clog2(AUTO_CYCLES + 1);

    logic [TW-1:0] r_auto_cnt;

    always_ff @(posedge CLK32MHz) begin
        if (greset) begin
            r_auto_cnt <= '0;
        end else if (w_state_nx == ARMED && r_state != ARMED) begin
            r_auto_cnt <= TW'(AUTO_CYCLES);
        end else if (r_state == ARMED && r_auto_cnt != '0) begin
            r_auto_cnt <= r_auto_cnt - TW'(1);
        end
    end

    assign w_auto_fire = (r_auto_cnt == '0);
`else
    assign w_auto_fire = 1'b0;
`endif

    capture_ram #(
        .DEPTH (DEPTH)
    ) u_ram (
        .CLK32MHz (CLK32MHz),
        .i_we     (w_we),
        .i_waddr  (r_wr_ptr),
        .i_wdata  (ad_data),
        .i_re     (w_re),
        .i_raddr  (r_rd_addr),
        .o_rdata  (w_ram_rdata)
    );

    assign rd.rd_valid = r_rd_valid;
    assign rd.rd_data  = r_rd_data;
    assign rd.rd_last  = r_rd_last;

endmodule
